// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared store-path op codes, byte-enable constants and lane helper.
package store_buffer_pkg;
  typedef enum logic {DM_OP_NONE = 1'b0, DM_OP_WRITE = 1'b1} dm_op_e;
  localparam logic ST_OP_WORD = 1'b0;
  localparam logic ST_OP_BYTE = 1'b1;
  localparam logic [3:0] BE_ALL = 4'b1111;
  function automatic logic [3:0] lane_onehot(input logic [1:0] off);
    return 4'b0001 << off;
  endfunction
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: store, load-lookup and drain signals of the store buffer.
// dm_rd exists only when STORE_BUFFER_TRACE_EN is defined.
interface store_buffer_if #(parameter int AW = 32);
  logic st_valid, st_ready, st_op;
  logic [AW-1:0] st_addr;
  logic [31:0] st_wd, st_pc;
  logic ld_valid, ld_op, ld_fwd, ld_stall;
  logic [AW-1:0] ld_addr;
  logic [31:0] ld_fwd_data;
  logic dm_we, dm_ack, empty;
  logic [AW-1:0] dm_addr;
  logic [31:0] dm_wd, dm_pc;
  logic [3:0] dm_be;
`ifdef STORE_BUFFER_TRACE_EN
  logic [31:0] dm_rd;
  modport master(output st_valid, st_op, st_addr, st_wd, st_pc, ld_valid, ld_op, ld_addr, dm_ack, dm_rd,
                 input st_ready, ld_fwd, ld_fwd_data, ld_stall, dm_we, dm_addr, dm_wd, dm_be, dm_pc, empty);
  modport slave(input st_valid, st_op, st_addr, st_wd, st_pc, ld_valid, ld_op, ld_addr, dm_ack, dm_rd,
                output st_ready, ld_fwd, ld_fwd_data, ld_stall, dm_we, dm_addr, dm_wd, dm_be, dm_pc, empty);
`else
  modport master(output st_valid, st_op, st_addr, st_wd, st_pc, ld_valid, ld_op, ld_addr, dm_ack,
                 input st_ready, ld_fwd, ld_fwd_data, ld_stall, dm_we, dm_addr, dm_wd, dm_be, dm_pc, empty);
  modport slave(input st_valid, st_op, st_addr, st_wd, st_pc, ld_valid, ld_op, ld_addr, dm_ack,
                output st_ready, ld_fwd, ld_fwd_data, ld_stall, dm_we, dm_addr, dm_wd, dm_be, dm_pc, empty);
`endif
endinterface

// File: rtl/store_buffer_lane_align.sv
// sb_lane_align: maps (op, byte offset, data) to byte enables and lane-placed data.
module sb_lane_align
  import store_buffer_pkg::*;
(
  input  logic        op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wd_i,
  output logic [3:0]  be_o,
  output logic [31:0] data_o
);
  assign be_o = (op_i == ST_OP_BYTE) ? lane_onehot(off_i) : BE_ALL;
  assign data_o = (op_i == ST_OP_BYTE) ? ({24'b0, wd_i[7:0]} << {off_i, 3'b000}) : wd_i;
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM-stage store path and data memory,
// with load forwarding/stall lookup. Optional drain trace under STORE_BUFFER_TRACE_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = 32
) (
  input logic clk,
  input logic reset,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, idx;
  logic [PW:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-3:0] wa_q [DEPTH];
  logic [31:0] wd_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [3:0] be_q [DEPTH];
  logic [3:0] st_be, ld_need, hit_be;
  logic [31:0] st_data, hit_data, unused_ld_data;
  logic push, pop, hit, covered;
  sb_lane_align u_st_align (.op_i(sb.st_op), .off_i(sb.st_addr[1:0]), .wd_i(sb.st_wd), .be_o(st_be), .data_o(st_data));
  sb_lane_align u_ld_need (.op_i(sb.ld_op), .off_i(sb.ld_addr[1:0]), .wd_i(32'b0), .be_o(ld_need), .data_o(unused_ld_data));
  assign sb.st_ready = count_q != (PW+1)'(DEPTH);
  assign sb.empty = count_q == '0;
  assign sb.dm_we = !sb.empty;
  assign sb.dm_addr = {wa_q[head_q], 2'b00};
  assign sb.dm_wd = wd_q[head_q];
  assign sb.dm_be = be_q[head_q];
  assign sb.dm_pc = pc_q[head_q];
  assign push = sb.st_valid && sb.st_ready;
  assign pop = sb.dm_we && sb.dm_ack;
  always_comb begin
    head_d = head_q + PW'(pop);
    tail_d = tail_q + PW'(push);
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    valid_d = valid_q;
    if (pop) valid_d[head_q] = 1'b0;
    if (push) valid_d[tail_q] = 1'b1;
  end
  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit = 1'b0;
    hit_be = '0;
    hit_data = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && wa_q[idx] == sb.ld_addr[AW-1:2]) begin
        hit = 1'b1;
        hit_be = be_q[idx];
        hit_data = wd_q[idx];
      end
    end
  end
  assign covered = (hit_be & ld_need) == ld_need;
  assign sb.ld_fwd = sb.ld_valid && hit && covered;
  assign sb.ld_stall = sb.ld_valid && hit && !covered;
  assign sb.ld_fwd_data = sb.ld_fwd ? hit_data : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      wa_q[tail_q] <= sb.st_addr[AW-1:2];
      wd_q[tail_q] <= st_data;
      be_q[tail_q] <= st_be;
      pc_q[tail_q] <= sb.st_pc;
    end
  end
`ifdef STORE_BUFFER_TRACE_EN
  logic [31:0] merged;
  always_comb begin
    merged = sb.dm_rd;
    for (int l = 0; l < 4; l++) if (sb.dm_be[l]) merged[8*l +: 8] = sb.dm_wd[8*l +: 8];
  end
  always_ff @(posedge clk) begin
    if (!reset && pop) $display("@%h: *%h <= %h", sb.dm_pc, sb.dm_addr, merged);
  end
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table vectors, directed corner sequences and a randomized run
// against a queue-based reference model of the store buffer.
module tb_store_buffer;
  import store_buffer_pkg::*;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  store_buffer_if #(.AW(32)) sb();
  store_buffer #(.DEPTH(4), .AW(32)) dut (.clk(clk), .reset(reset), .sb(sb));
`ifdef STORE_BUFFER_TRACE_EN
  initial sb.dm_rd = 32'h0;
`endif
  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic op;
    logic [31:0] addr, wd, exp_addr;
    logic [3:0] exp_be;
    logic [31:0] exp_wd;
  } vec_t;
  typedef struct {
    logic [31:0] addr, wd, pc;
    logic [3:0] be;
  } ent_t;
  ent_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    sb.st_valid = 0; sb.st_op = 0; sb.st_addr = 0; sb.st_wd = 0; sb.st_pc = 0;
    sb.ld_valid = 0; sb.ld_op = 0; sb.ld_addr = 0; sb.dm_ack = 0;
  endtask
  task automatic push(input logic op, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc);
    sb.st_op = op; sb.st_addr = addr; sb.st_wd = wd; sb.st_pc = pc; sb.st_valid = 1;
    tick();
    sb.st_valid = 0;
  endtask
  task automatic load(input logic op, input logic [31:0] addr);
    sb.ld_valid = 1; sb.ld_op = op; sb.ld_addr = addr;
    #1;
  endtask
  task automatic do_reset();
    reset = 1;
    #3;
    @(negedge clk);
    reset = 0;
    tick();
  endtask

  task automatic run_random(input int cycles);
    logic [3:0] need;
    logic [31:0] wa;
    int y;
    logic cov, exp_fwd, exp_stall, do_push, do_pop;
    ent_t e;
    for (int c = 0; c < cycles; c++) begin
      sb.st_valid = 1'($urandom % 2);
      sb.st_op = 1'($urandom % 2);
      sb.st_addr = 32'h100 + 32'(($urandom % 4) * 4) + 32'($urandom % 4);
      sb.st_wd = $urandom;
      sb.st_pc = 32'h8000 + 32'(c);
      sb.ld_valid = 1'($urandom % 2);
      sb.ld_op = 1'($urandom % 2);
      sb.ld_addr = 32'h100 + 32'(($urandom % 5) * 4) + 32'($urandom % 4);
      sb.dm_ack = ($urandom % 3) != 0;
      #1;
      chk("rnd_ready", sb.st_ready, mq.size() < 4);
      chk("rnd_empty", sb.empty, mq.size() == 0);
      chk("rnd_dm_we", sb.dm_we, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("rnd_dm_addr", sb.dm_addr, mq[0].addr);
        chk("rnd_dm_wd", sb.dm_wd, mq[0].wd);
        chk("rnd_dm_be", sb.dm_be, mq[0].be);
        chk("rnd_dm_pc", sb.dm_pc, mq[0].pc);
      end
      need = sb.ld_op ? (4'b0001 << sb.ld_addr[1:0]) : 4'hF;
      wa = {sb.ld_addr[31:2], 2'b00};
      y = -1;
      for (int j = mq.size() - 1; j >= 0; j--) if (y < 0 && mq[j].addr == wa) y = j;
      cov = (y >= 0) && ((mq[y].be & need) == need);
      exp_fwd = sb.ld_valid && cov;
      exp_stall = sb.ld_valid && (y >= 0) && !cov;
      chk("rnd_ld_fwd", sb.ld_fwd, exp_fwd);
      chk("rnd_ld_stall", sb.ld_stall, exp_stall);
      if (exp_fwd) chk("rnd_ld_data", sb.ld_fwd_data, mq[y].wd);
      do_push = sb.st_valid && mq.size() < 4;
      do_pop = sb.dm_ack && mq.size() != 0;
      e.addr = {sb.st_addr[31:2], 2'b00};
      e.be = sb.st_op ? (4'b0001 << sb.st_addr[1:0]) : 4'hF;
      e.wd = sb.st_op ? ((sb.st_wd & 32'hFF) << (8 * sb.st_addr[1:0])) : sb.st_wd;
      e.pc = sb.st_pc;
      tick();
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{ST_OP_WORD, 32'h10, 32'h12345678, 32'h10, 4'hF, 32'h12345678};
    vecs[1] = '{ST_OP_WORD, 32'h17, 32'hCAFEBABE, 32'h14, 4'hF, 32'hCAFEBABE};
    vecs[2] = '{ST_OP_BYTE, 32'h20, 32'hFFFFFF11, 32'h20, 4'h1, 32'h00000011};
    vecs[3] = '{ST_OP_BYTE, 32'h21, 32'h00FFFF22, 32'h20, 4'h2, 32'h00002200};
    vecs[4] = '{ST_OP_BYTE, 32'h22, 32'h00000033, 32'h20, 4'h4, 32'h00330000};
    vecs[5] = '{ST_OP_BYTE, 32'h13, 32'h000000AB, 32'h10, 4'h8, 32'hAB000000};
    idle();
    reset = 1;
    sb.ld_valid = 1;
    #3;
    chk("rst_ready", sb.st_ready, 1);
    chk("rst_empty", sb.empty, 1);
    chk("rst_dm_we", sb.dm_we, 0);
    chk("rst_ld_fwd", sb.ld_fwd, 0);
    chk("rst_ld_stall", sb.ld_stall, 0);
    @(negedge clk);
    reset = 0;
    sb.ld_valid = 0;
    tick();

    foreach (vecs[i]) begin
      push(vecs[i].op, vecs[i].addr, vecs[i].wd, 32'h1000 + 32'(i * 4));
      #1;
      chk("vec_empty", sb.empty, 0);
      chk("vec_dm_we", sb.dm_we, 1);
      chk("vec_dm_addr", sb.dm_addr, vecs[i].exp_addr);
      chk("vec_dm_be", sb.dm_be, vecs[i].exp_be);
      chk("vec_dm_wd", sb.dm_wd, vecs[i].exp_wd);
      chk("vec_dm_pc", sb.dm_pc, 32'h1000 + 32'(i * 4));
      sb.dm_ack = 1;
      tick();
      sb.dm_ack = 0;
      #1;
      chk("vec_drained", sb.empty, 1);
    end

    push(ST_OP_BYTE, 32'h13, 32'hAB, 32'h0);
    load(ST_OP_BYTE, 32'h13);
    chk("ldb_fwd", sb.ld_fwd, 1);
    chk("ldb_stall", sb.ld_stall, 0);
    chk("ldb_data", sb.ld_fwd_data, 32'hAB000000);
    load(ST_OP_WORD, 32'h10);
    chk("ldw_fwd", sb.ld_fwd, 0);
    chk("ldw_stall", sb.ld_stall, 1);
    load(ST_OP_BYTE, 32'h12);
    chk("ldb_other_lane_stall", sb.ld_stall, 1);
    load(ST_OP_WORD, 32'h14);
    chk("ld_miss_fwd", sb.ld_fwd, 0);
    chk("ld_miss_stall", sb.ld_stall, 0);
    load(ST_OP_WORD, 32'h10);
    sb.dm_ack = 1;
    tick();
    sb.dm_ack = 0;
    #1;
    chk("stall_cleared", sb.ld_stall, 0);
    sb.ld_valid = 0;

    push(ST_OP_WORD, 32'h20, 32'h1, 32'h0);
    push(ST_OP_WORD, 32'h20, 32'h2, 32'h0);
    load(ST_OP_WORD, 32'h20);
    chk("youngest_fwd", sb.ld_fwd, 1);
    chk("youngest_data", sb.ld_fwd_data, 32'h2);
    push(ST_OP_BYTE, 32'h21, 32'h77, 32'h0);
    load(ST_OP_WORD, 32'h20);
    chk("youngest_partial_stall", sb.ld_stall, 1);
    chk("youngest_partial_fwd", sb.ld_fwd, 0);
    sb.ld_valid = 0;
    sb.dm_ack = 1;
    repeat (3) tick();
    sb.dm_ack = 0;
    #1;
    chk("youngest_drained", sb.empty, 1);

    for (int k = 0; k < 4; k++) push(ST_OP_WORD, 32'h40 + 32'(k * 4), 32'(k), 32'h2000 + 32'(k));
    #1;
    chk("full_ready", sb.st_ready, 0);
    sb.st_valid = 1; sb.st_addr = 32'h80;
    tick();
    sb.st_valid = 0;
    #1;
    chk("full_head_kept", sb.dm_addr, 32'h40);
    chk("full_still", sb.st_ready, 0);
    sb.st_valid = 1; sb.st_addr = 32'h84; sb.dm_ack = 1;
    #1;
    chk("full_push_ack_ready", sb.st_ready, 0);
    tick();
    sb.st_valid = 0;
    for (int k = 1; k < 4; k++) begin
      #1;
      chk("full_order", sb.dm_addr, 32'h40 + 32'(k * 4));
      tick();
    end
    sb.dm_ack = 0;
    #1;
    chk("full_refused_empty", sb.empty, 1);

    push(ST_OP_WORD, 32'h200, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      sb.st_valid = 1; sb.st_addr = 32'h204 + 32'(i * 4); sb.dm_ack = 1;
      #1;
      chk("wrap_order", sb.dm_addr, 32'h200 + 32'(i * 4));
      chk("wrap_ready", sb.st_ready, 1);
      tick();
    end
    sb.st_valid = 0;
    #1;
    chk("wrap_last", sb.dm_addr, 32'h218);
    tick();
    sb.dm_ack = 0;
    #1;
    chk("wrap_empty", sb.empty, 1);

    for (int k = 0; k < 3; k++) push(ST_OP_WORD, 32'h300 + 32'(k * 4), 32'(k), 32'h0);
    #1;
    chk("pre_arst_empty", sb.empty, 0);
    reset = 1;
    #1;
    chk("arst_empty", sb.empty, 1);
    chk("arst_dm_we", sb.dm_we, 0);
    chk("arst_ready", sb.st_ready, 1);
    @(negedge clk);
    reset = 0;
    tick();

    run_random(500);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the MEM-stage store path and the data memory.
- Accepts stores from the pipeline, aligns them into byte lanes and queues them FIFO.
- Retires one entry per cycle into the data memory's write port.
- Loads that hit a queued store are either forwarded the data or stalled.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2.
AW, 32, byte-address width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
st_valid  input  1  store request this cycle
st_ready  output  1  buffer can accept a store (not full)
st_op  input  1  0 = word store, 1 = byte store
st_addr  input  AW  store byte address
st_wd  input  32  store data, unaligned (byte store uses bits 7:0)
st_pc  input  32  PC of the store instruction, carried for trace
ld_valid  input  1  load lookup this cycle
ld_op  input  1  0 = word load, 1 = byte load
ld_addr  input  AW  load byte address
ld_fwd  output  1  load fully covered by buffered data
ld_fwd_data  output  32  forwarded word, lanes as stored in memory
ld_stall  output  1  load partially overlaps buffered data; stall pipeline
dm_we  output  1  drain write strobe to data memory
dm_ack  input  1  data memory accepted the write this cycle (tie 1 for single-cycle memory)
dm_addr  output  AW  drain word address, bits 1:0 = 0
dm_wd  output  32  drain data, lane-aligned
dm_be  output  4  drain byte enables
dm_pc  output  32  PC of draining store
empty  output  1  no valid entries

Behaviour:
Reset:
- Asynchronous, active-high.
- Head, tail and count go to 0; all valid bits cleared.
- After reset: st_ready=1, empty=1; dm_we, ld_fwd and ld_stall are 0.
- A reset mid-operation silently drops every queued store.

Alignment (combinational on push):
- Word store: be=4'b1111, data=st_wd.
- Byte store: be=one-hot at lane st_addr[1:0], and st_wd[7:0] is replicated into that lane (other lanes don't-care, stored 0).
- Word address = {st_addr[AW-1:2], 2'b00}.
- A misaligned word store (st_addr[1:0] != 0) is accepted with the address bits forced to 0.

Push:
- An entry is written at tail on the rising edge when st_valid && st_ready.
- st_ready = (count != DEPTH) and is computed from registered count only.
- When full, a push is refused even if a drain completes in the same cycle.

Drain:
- dm_we = !empty. dm_addr, dm_wd, dm_be and dm_pc come combinationally from the head entry.
- Head retires on the edge where dm_we && dm_ack.
- Entries are never merged; strict program order.

Simultaneous push and drain:
- Count is unchanged; head and tail both advance.
- Pointers wrap modulo DEPTH.

Load lookup (combinational, valid only when ld_valid):
- need = 1111 for a word load, one-hot at ld_addr[1:0] for a byte load.
- Match = valid entry with the same word address. The youngest match (closest to tail) decides.
- If youngest.be covers need: ld_fwd=1 and ld_fwd_data=youngest data.
- Else, if any match exists: ld_stall=1, held until the draining entries clear it.
- Else both are 0.
- ld_fwd and ld_stall are never both 1.
- A store pushed in the same cycle is not visible to a lookup until the next cycle.

Optional Feature:
STORE_BUFFER_TRACE_EN:
- When defined, each retiring drain prints "@<dm_pc>: *<dm_addr> <= <merged word>" via $display. The merged word is dm_wd with non-enabled lanes taken from the memory read-back input, which exists only under this macro: dm_rd, input, 32.
- When undefined, there is no dm_rd port and no display.

Decomposition:
- Shared definitions file holds ST_OP_WORD=1'b0, ST_OP_BYTE=1'b1 and BE_ALL=4'b1111, alongside the existing DM op codes.
- One natural sub-module: sb_lane_align. It is combinational and maps (op, addr[1:0], wd) to (be, lane data). It is reused for the load need-mask.

Test Plan:
1. Push sw 0x00000010 <= 0x12345678 with dm_ack=0 → empty=0, dm_we=1, dm_addr=0x10, dm_be=1111. Raise dm_ack → retires next edge, empty=1.
2. Push sb addr 0x13 data 0xAB → dm_be=1000, dm_wd[31:24]=0xAB. Byte load at 0x13 → ld_fwd=1. Word load at 0x10 → ld_stall=1.
3. Hold dm_ack=0 and push 4 stores → st_ready=0 after the 4th. A 5th st_valid is ignored. Then assert push and ack in the same cycle → push still refused.
4. sw 0x20 <= 0x1, then sw 0x20 <= 0x2, dm_ack=0 → word load 0x20 gives ld_fwd_data=0x2 (youngest wins).
5. Run 6 push+drain cycles with DEPTH=4 → pointers wrap and drain order equals push order.
6. Assert reset asynchronously with 3 entries queued → empty=1, dm_we=0 immediately, without waiting for a clock edge.
